// File: rtl/cost_ctrl.sv
// Epoch sequencer for the cost accumulator. Gates delta pairs into the
// accumulator, restarts the sum on each epoch's first sample, captures the
// epoch cost and checks it against a latched convergence threshold.
module cost_ctrl #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FRAC    = 24,
  parameter int unsigned NSAMPLE = 4,
  parameter int unsigned SCNT_W  = 8,
  parameter int unsigned ECNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic [WIDTH-1:0]  i_thresh,
  input  logic [ECNT_W-1:0] i_max_epoch,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [WIDTH-1:0]  i_d1,
  input  logic [WIDTH-1:0]  i_d2,
  output logic [WIDTH-1:0]  o_d1,
  output logic [WIDTH-1:0]  o_d2,
  output logic              o_acc_en,
  input  logic [WIDTH-1:0]  i_acc,
  output logic [WIDTH-1:0]  o_cost,
  output logic              o_cost_valid,
  output logic [ECNT_W-1:0] o_epoch,
  output logic [SCNT_W-1:0] o_sample_idx,
  output logic              o_busy,
  output logic              o_converged,
  output logic              o_done
);

  // FRAC only documents the fixed-point format; it must still fit the word.
  if (NSAMPLE < 1 || FRAC >= WIDTH || NSAMPLE > (2 ** SCNT_W)) begin : g_param_err
    $error("cost_ctrl: illegal parameter combination");
  end

  localparam logic [SCNT_W-1:0] LastIdx = SCNT_W'(NSAMPLE - 1);

  typedef enum logic [2:0] {
    StIdle,
    StCollect,
    StCapture,
    StCheck,
    StDone
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    thresh_q, thresh_d;
  logic [ECNT_W-1:0]   max_epoch_q, max_epoch_d;
  logic [ECNT_W-1:0]   epoch_q, epoch_d;
  logic [SCNT_W-1:0]   sample_idx_q, sample_idx_d;
  logic [WIDTH-1:0]    cost_q, cost_d;
  logic                converged_q, converged_d;
  logic                done_q, done_d;

  logic                accept;
  logic [ECNT_W:0]     epoch_next;

  // Combinational gating towards the accumulator and status outputs
  always_comb begin
    o_ready      = (state_q == StCollect);
    accept       = i_valid && o_ready;
    o_d1         = accept ? i_d1 : '0;
    o_d2         = accept ? i_d2 : '0;
    // Dropping enable on the first sample makes the accumulator load it fresh.
    o_acc_en     = !((state_q == StCollect) && (sample_idx_q == '0));
    o_cost_valid = (state_q == StCheck);
    o_busy       = (state_q != StIdle) && (state_q != StDone);
    o_cost       = cost_q;
    o_epoch      = epoch_q;
    o_sample_idx = sample_idx_q;
    o_converged  = converged_q;
    o_done       = done_q;
  end

  // One extra bit so the last-epoch compare cannot wrap
  assign epoch_next = {1'b0, epoch_q} + (ECNT_W + 1)'(1);

  // Next-state logic for the epoch sequencer
  always_comb begin
    state_d      = state_q;
    thresh_d     = thresh_q;
    max_epoch_d  = max_epoch_q;
    epoch_d      = epoch_q;
    sample_idx_d = sample_idx_q;
    cost_d       = cost_q;
    converged_d  = converged_q;
    done_d       = done_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (i_start) begin
          thresh_d     = i_thresh;
          max_epoch_d  = (i_max_epoch == '0) ? ECNT_W'(1) : i_max_epoch;
          epoch_d      = '0;
          sample_idx_d = '0;
          converged_d  = 1'b0;
          done_d       = 1'b0;
          state_d      = StCollect;
        end
      end
      StCollect: begin
        if (accept) begin
          if (sample_idx_q == LastIdx) begin
            sample_idx_d = '0;
            state_d      = StCapture;
          end else begin
            sample_idx_d = sample_idx_q + SCNT_W'(1);
          end
        end
      end
      StCapture: begin
        cost_d  = i_acc;
        state_d = StCheck;
      end
      StCheck: begin
        if ($signed(cost_q) < $signed(thresh_q)) begin
          converged_d = 1'b1;
          done_d      = 1'b1;
          state_d     = StDone;
        end else if (epoch_next == {1'b0, max_epoch_q}) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          epoch_d = (&epoch_q) ? epoch_q : epoch_next[ECNT_W-1:0];
          state_d = StCollect;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      thresh_q     <= '0;
      max_epoch_q  <= '0;
      epoch_q      <= '0;
      sample_idx_q <= '0;
      cost_q       <= '0;
      converged_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      thresh_q     <= thresh_d;
      max_epoch_q  <= max_epoch_d;
      epoch_q      <= epoch_d;
      sample_idx_q <= sample_idx_d;
      cost_q       <= cost_d;
      converged_q  <= converged_d;
      done_q       <= done_d;
    end
  end

endmodule

// File: tb/tb_cost_ctrl.sv
// Self-checking bench for cost_ctrl: a behavioural accumulator closes the
// loop, and a per-run reference model predicts epoch costs and the outcome.
module tb_cost_ctrl;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned FRAC    = 24;
  localparam int unsigned NSAMPLE = 4;
  localparam int unsigned SCNT_W  = 8;
  localparam int unsigned ECNT_W  = 16;
  localparam int          MaxEp   = 8;

  logic              clk;
  logic              rst;
  logic              i_start;
  logic [WIDTH-1:0]  i_thresh;
  logic [ECNT_W-1:0] i_max_epoch;
  logic              i_valid;
  logic              o_ready;
  logic [WIDTH-1:0]  i_d1, i_d2, o_d1, o_d2;
  logic              o_acc_en;
  logic [WIDTH-1:0]  i_acc;
  logic [WIDTH-1:0]  o_cost;
  logic              o_cost_valid;
  logic [ECNT_W-1:0] o_epoch;
  logic [SCNT_W-1:0] o_sample_idx;
  logic              o_busy, o_converged, o_done;

  cost_ctrl #(
    .WIDTH  (WIDTH),
    .FRAC   (FRAC),
    .NSAMPLE(NSAMPLE),
    .SCNT_W (SCNT_W),
    .ECNT_W (ECNT_W)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_start     (i_start),
    .i_thresh    (i_thresh),
    .i_max_epoch (i_max_epoch),
    .i_valid     (i_valid),
    .o_ready     (o_ready),
    .i_d1        (i_d1),
    .i_d2        (i_d2),
    .o_d1        (o_d1),
    .o_d2        (o_d2),
    .o_acc_en    (o_acc_en),
    .i_acc       (i_acc),
    .o_cost      (o_cost),
    .o_cost_valid(o_cost_valid),
    .o_epoch     (o_epoch),
    .o_sample_idx(o_sample_idx),
    .o_busy      (o_busy),
    .o_converged (o_converged),
    .o_done      (o_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Fixed-point product, as the downstream accumulator would form it
  function automatic logic [WIDTH-1:0] prod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic signed [2*WIDTH-1:0] p;
    p = $signed(a) * $signed(b);
    return p[FRAC +: WIDTH];
  endfunction

  // Accumulator stand-in: en=0 loads the current product, en=1 adds it
  logic [WIDTH-1:0] acc_q = 32'hdead_beef;
  always @(posedge clk) acc_q <= o_acc_en ? acc_q + prod(o_d1, o_d2) : prod(o_d1, o_d2);
  assign i_acc = acc_q;

  // Reference model state for the current run
  logic [WIDTH-1:0] d1s [0:MaxEp*NSAMPLE-1];
  logic [WIDTH-1:0] d2s [0:MaxEp*NSAMPLE-1];
  logic [WIDTH-1:0] exp_cost [0:MaxEp-1];
  int               exp_pulses = 0;
  int               pulse_cnt  = 0;

  // Every cost pulse must carry the next predicted epoch cost
  always @(negedge clk) begin
    if (rst && o_cost_valid) begin
      if (pulse_cnt < exp_pulses) check_eq("cost", o_cost, exp_cost[pulse_cnt]);
      else check_eq("extra_cost_pulse", pulse_cnt, exp_pulses);
      pulse_cnt++;
    end
  end

  task automatic plan(input logic [WIDTH-1:0] thr, input int maxe,
                      output int n_ep, output bit conv);
    int maxeff;
    logic [WIDTH-1:0] sum;
    maxeff = (maxe == 0) ? 1 : maxe;
    n_ep = maxeff;
    conv = 1'b0;
    for (int e = 0; e < maxeff; e++) begin
      sum = '0;
      for (int k = 0; k < NSAMPLE; k++) sum += prod(d1s[e*NSAMPLE+k], d2s[e*NSAMPLE+k]);
      exp_cost[e] = sum;
      if ($signed(sum) < $signed(thr)) begin
        n_ep = e + 1;
        conv = 1'b1;
        break;
      end
    end
    exp_pulses = n_ep;
    pulse_cnt  = 0;
  endtask

  task automatic fill_const(input logic [WIDTH-1:0] v);
    for (int i = 0; i < MaxEp*NSAMPLE; i++) begin
      d1s[i] = v;
      d2s[i] = v;
    end
  endtask

  task automatic fill_rand();
    for (int i = 0; i < MaxEp*NSAMPLE; i++) begin
      d1s[i] = $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
      d2s[i] = $urandom_range(0, 32'h0200_0000) - 32'h0100_0000;
    end
  endtask

  task automatic do_start(input logic [WIDTH-1:0] thr, input int maxe);
    i_thresh    = thr;
    i_max_epoch = ECNT_W'(maxe);
    i_start     = 1'b1;
    @(posedge clk); #1;
    i_start     = 1'b0;
    i_thresh    = $urandom;
    i_max_epoch = ECNT_W'($urandom);
    @(negedge clk);
    check_eq("start_busy", o_busy, 1);
    check_eq("start_epoch", o_epoch, 0);
    check_eq("start_done", o_done, 0);
    check_eq("start_conv", o_converged, 0);
    @(posedge clk); #1;
  endtask

  // gap_mode: 0 = back-to-back, 1 = one idle cycle, 2 = 0..2 idle cycles
  task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int k,
                      input int gap_mode, input bit poke);
    int gap;
    bit acc;
    gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : int'($urandom_range(0, 2));
    for (int g = 0; g < gap; g++) begin
      i_valid = 1'b0;
      i_d1    = $urandom;
      i_d2    = $urandom;
      i_start = poke && ($urandom_range(0, 1) == 1);
      @(negedge clk);
      check_eq("gate_d1_idle", o_d1, 0);
      check_eq("gate_d2_idle", o_d2, 0);
      @(posedge clk); #1;
    end
    i_start = 1'b0;
    i_valid = 1'b1;
    i_d1    = a;
    i_d2    = b;
    acc     = 1'b0;
    for (int c = 0; c < 16 && !acc; c++) begin
      @(negedge clk);
      if (o_ready) begin
        acc = 1'b1;
        check_eq("acc_en", o_acc_en, (k != 0));
        check_eq("gate_d1", o_d1, a);
        check_eq("gate_d2", o_d2, b);
        check_eq("sample_idx", o_sample_idx, k);
      end
      @(posedge clk); #1;
    end
    check_eq("ready_seen", acc, 1);
    i_valid = 1'b0;
    i_d1    = $urandom;
    i_d2    = $urandom;
  endtask

  task automatic feed(input int n_ep, input int gap_mode, input bit poke);
    for (int e = 0; e < n_ep; e++)
      for (int k = 0; k < NSAMPLE; k++)
        send(d1s[e*NSAMPLE+k], d2s[e*NSAMPLE+k], k, gap_mode, poke);
  endtask

  task automatic run(input logic [WIDTH-1:0] thr, input int maxe, input int gap_mode,
                     input bit poke);
    int n_ep;
    bit conv;
    plan(thr, maxe, n_ep, conv);
    do_start(thr, maxe);
    feed(n_ep, gap_mode, poke);
    // Capture cycle, then the check cycle carrying the pulse
    @(negedge clk);
    check_eq("lat_capture", o_cost_valid, 0);
    @(negedge clk);
    check_eq("lat_check", o_cost_valid, 1);
    check_eq("lat_not_done", o_done, 0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (o_done) break;
    end
    check_eq("done", o_done, 1);
    check_eq("converged", o_converged, conv);
    check_eq("epoch", o_epoch, n_ep - 1);
    check_eq("pulses", pulse_cnt, n_ep);
    check_eq("idle_busy", o_busy, 0);
    check_eq("idle_ready", o_ready, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_ep;
    bit conv;
    rst         = 1'b0;
    i_start     = 1'b0;
    i_valid     = 1'b0;
    i_thresh    = '0;
    i_max_epoch = '0;
    i_d1        = '0;
    i_d2        = '0;

    // Held in reset with random inputs: everything quiet
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      i_start  = $urandom_range(0, 1);
      i_valid  = $urandom_range(0, 1);
      i_d1     = $urandom;
      i_d2     = $urandom;
      i_thresh = $urandom;
    end
    @(negedge clk);
    check_eq("rst_ready", o_ready, 0);
    check_eq("rst_acc_en", o_acc_en, 1);
    check_eq("rst_d1", o_d1, 0);
    check_eq("rst_d2", o_d2, 0);
    check_eq("rst_cost", o_cost, 0);
    check_eq("rst_cost_valid", o_cost_valid, 0);
    check_eq("rst_epoch", o_epoch, 0);
    check_eq("rst_sample_idx", o_sample_idx, 0);
    check_eq("rst_busy", o_busy, 0);
    check_eq("rst_conv", o_converged, 0);
    check_eq("rst_done", o_done, 0);
    @(posedge clk); #1;
    i_start = 1'b0;
    i_valid = 1'b0;
    rst     = 1'b1;
    @(posedge clk); #1;

    // Single epoch, cost 1.0 not below 0.5, then exactly-above threshold
    fill_const(32'h0080_0000);
    run(32'h0080_0000, 1, 0, 1'b0);
    check_eq("cost_value_a", o_cost, 32'h0100_0000);
    run(32'h0100_0001, 1, 0, 1'b0);
    check_eq("cost_value_b", o_cost, 32'h0100_0000);

    // Three epochs with alternating idle cycles, never converging
    run(32'h8000_0000, 3, 1, 1'b0);

    // Reset part-way through epoch 1, then a clean single-epoch run
    plan(32'h8000_0000, 3, n_ep, conv);
    do_start(32'h8000_0000, 3);
    feed(1, 0, 1'b0);
    send(d1s[4], d2s[4], 0, 0, 1'b0);
    send(d1s[5], d2s[5], 1, 0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("midrst_busy", o_busy, 0);
    check_eq("midrst_ready", o_ready, 0);
    check_eq("midrst_epoch", o_epoch, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    run(32'h0080_0000, 1, 0, 1'b0);

    // Start pokes while busy are ignored; restart from DONE; max_epoch 0 acts as 1
    run(32'h8000_0000, 2, 2, 1'b1);
    run(32'h8000_0000, 0, 0, 1'b0);

    // Randomised runs against the model
    for (int r = 0; r < 25; r++) begin
      fill_rand();
      run($urandom_range(0, 32'h0400_0000) - 32'h0200_0000, $urandom_range(0, 5), 2,
          ($urandom_range(0, 1) == 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
